// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: state codes, memory/ALU opcodes,
// trap codes, datapath mux selects and the bundled output record.
package ctrl_pkg;

   localparam logic [3:0] S_FETCH_A = 4'd0;
   localparam logic [3:0] S_FETCH_R = 4'd1;
   localparam logic [3:0] S_FETCH_I = 4'd2;
   localparam logic [3:0] S_DECODE  = 4'd3;
   localparam logic [3:0] S_ALU_EX  = 4'd4;
   localparam logic [3:0] S_LS_ADDR = 4'd5;
   localparam logic [3:0] S_LD_WB   = 4'd6;
   localparam logic [3:0] S_ST_D    = 4'd7;
   localparam logic [3:0] S_ST_W    = 4'd8;
   localparam logic [3:0] S_BRANCH  = 4'd9;
   localparam logic [3:0] S_CALL    = 4'd10;
   localparam logic [3:0] S_NEXT_PC = 4'd11;
   localparam logic [3:0] S_PC_ONLY = 4'd12;
   localparam logic [3:0] S_TRAP    = 4'd13;
   localparam logic [3:0] S_VECTOR  = 4'd14;
   localparam logic [3:0] S_ERROR   = 4'd15;
   // Load data read drives exactly what fetch read drives, so it shares the code;
   // a pending-load flag picks the exit.
   localparam logic [3:0] S_LD_R    = S_FETCH_R;

   localparam logic [5:0] MOP_LD  = 6'b000000;
   localparam logic [5:0] MOP_ST  = 6'b000100;
   localparam logic [5:0] AOP_ADD = 6'b000000;

   localparam logic [5:0] TT_ILLEGAL = 6'd2;
   localparam logic [5:0] TT_MEM     = 6'd9;

   localparam logic [1:0] NPC_SEL_INC = 2'd0;
   localparam logic [1:0] NPC_SEL_TBR = 2'd1;
   localparam logic [1:0] NPC_SEL_BR  = 2'd2;
   localparam logic [1:0] CIN_SEL_PC  = 2'd0;
   localparam logic [1:0] CIN_SEL_ALU = 2'd2;
   localparam logic [1:0] CIN_SEL_MDR = 2'd3;
   localparam logic [1:0] RC_SEL_RD   = 2'd0;
   localparam logic [1:0] RC_SEL_R15  = 2'd3;
   localparam logic [1:0] MAR_SEL_ALU = 2'd0;
   localparam logic [1:0] MAR_SEL_PC  = 2'd1;
   localparam logic [1:0] MDR_SEL_RAM = 2'd0;
   localparam logic [1:0] MDR_SEL_RFA = 2'd1;
   localparam logic       DISP_22     = 1'b0;
   localparam logic       DISP_30     = 1'b1;

   typedef struct packed {
      logic       ire;
      logic       mdre;
      logic       mare;
      logic       pce;
      logic       npce;
      logic       npc_add;
      logic       rfe;
      logic       alue;
      logic       mfa;
      logic       mop_sel;
      logic       aop_sel;
      logic       ra_sel;
      logic       baux;
      logic       disp_sel;
      logic       tqe;
      logic [1:0] npc_sel;
      logic [1:0] alu_sel;
      logic [1:0] cin_sel;
      logic [1:0] rc_sel;
      logic [1:0] mar_sel;
      logic [1:0] mdr_sel;
      logic [5:0] op1;
      logic [5:0] tq_in;
      logic       err_halt;
   } ctrl_out_t;

   function automatic logic is_mem_wait(input logic [3:0] st);
      return (st == S_FETCH_R) || (st == S_ST_W);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// SPARC Bicc condition evaluator: maps a 4-bit cond field and {N,Z,V,C} to taken.
module branch_cond_eval
(
   input  logic [3:0] cond,
   input  logic [3:0] icc,
   output logic       taken
);

   logic w_n, w_z, w_v, w_c;
   logic w_base;

   assign {w_n, w_z, w_v, w_c} = icc;

   // cond[3] selects the complement of the lower eight conditions
   always_comb begin
      w_base = 1'b0;
      case (cond[2:0])
         3'd0:    w_base = 1'b0;
         3'd1:    w_base = w_z;
         3'd2:    w_base = w_z | (w_n ^ w_v);
         3'd3:    w_base = w_n ^ w_v;
         3'd4:    w_base = w_c | w_z;
         3'd5:    w_base = w_c;
         3'd6:    w_base = w_n;
         3'd7:    w_base = w_v;
         default: w_base = 1'b0;
      endcase
   end

   assign taken = w_base ^ cond[3];

endmodule

// File: rtl/control_sequencer.sv
// Microsequencer for the reduced SPARC datapath: fetch/decode/execute with an MFC
// watchdog and trap vectoring. Outputs are registered from the next state.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int MFC_TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Clr,
   input  logic [31:0] IR,
   input  logic [3:0]  PSR_icc,
   input  logic        MFC,
   input  logic        ET,
   output logic        IRE,
   output logic        MDRE,
   output logic        MARE,
   output logic        PCE,
   output logic        nPCE,
   output logic        nPC_ADD,
   output logic        RFE,
   output logic        ALUE,
   output logic        MFA,
   output logic        MOP_SEL,
   output logic        AOP_SEL,
   output logic        RA_SEL,
   output logic        BAUX,
   output logic        DISP_SEL,
   output logic        tQE,
   output logic [1:0]  nPC_SEL,
   output logic [1:0]  ALU_SEL,
   output logic [1:0]  CIN_SEL,
   output logic [1:0]  RC_SEL,
   output logic [1:0]  MAR_SEL,
   output logic [1:0]  MDR_SEL,
   output logic [5:0]  OP1,
   output logic [5:0]  tQ_IN,
   output logic        ErrHalt,
   output logic [3:0]  State
);

   localparam int              WD_W    = $clog2(MFC_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MFC_TIMEOUT - 1);

   logic [3:0]      r_state, w_state_nxt;
   logic            r_live;
   logic            r_ld_pend, w_ld_pend_nxt;
   logic            r_taken, w_taken_nxt, w_taken;
   logic [5:0]      r_code, w_code_nxt;
   logic [WD_W-1:0] r_wd;
   logic            w_wd_exp;
   ctrl_out_t       r_out, w_out_nxt;
   logic            w_unused_ir;

   assign w_unused_ir = ^{IR[29], IR[20:14], IR[12:0]};
   assign w_wd_exp    = (r_wd == WD_LAST) && !MFC;

   branch_cond_eval u_bce (
      .cond  (IR[28:25]),
      .icc   (PSR_icc),
      .taken (w_taken)
   );

   // Next-state selection and trap/branch bookkeeping
   always_comb begin
      w_state_nxt   = r_state;
      w_ld_pend_nxt = r_ld_pend;
      w_code_nxt    = r_code;
      case (r_state)
         S_FETCH_A: begin
            // One idle cycle after reset release so FETCH_A shows its outputs
            if (r_live) begin
               w_state_nxt   = S_FETCH_R;
               w_ld_pend_nxt = 1'b0;
            end else begin
               w_state_nxt = S_FETCH_A;
            end
         end
         S_FETCH_R: begin
            if (MFC) begin
               w_state_nxt = r_ld_pend ? S_LD_WB : S_FETCH_I;
            end else if (w_wd_exp) begin
               w_state_nxt = S_TRAP;
               w_code_nxt  = TT_MEM;
            end else begin
               w_state_nxt = S_FETCH_R;
            end
         end
         S_FETCH_I: w_state_nxt = S_DECODE;
         S_DECODE: begin
            case (IR[31:30])
               2'b10: w_state_nxt = S_ALU_EX;
               2'b11: w_state_nxt = S_LS_ADDR;
               2'b01: w_state_nxt = S_CALL;
               2'b00: begin
                  if (IR[24:22] == 3'b010) begin
                     w_state_nxt = S_BRANCH;
                  end else begin
                     w_state_nxt = S_TRAP;
                     w_code_nxt  = TT_ILLEGAL;
                  end
               end
               default: begin
                  w_state_nxt = S_TRAP;
                  w_code_nxt  = TT_ILLEGAL;
               end
            endcase
         end
         S_ALU_EX: w_state_nxt = S_NEXT_PC;
         S_LS_ADDR: begin
            if (IR[21]) begin
               w_state_nxt = S_ST_D;
            end else begin
               w_state_nxt   = S_LD_R;
               w_ld_pend_nxt = 1'b1;
            end
         end
         S_LD_WB:   w_state_nxt = S_NEXT_PC;
         S_ST_D:    w_state_nxt = S_ST_W;
         S_ST_W: begin
            if (MFC) begin
               w_state_nxt = S_NEXT_PC;
            end else if (w_wd_exp) begin
               w_state_nxt = S_TRAP;
               w_code_nxt  = TT_MEM;
            end else begin
               w_state_nxt = S_ST_W;
            end
         end
         S_BRANCH:  w_state_nxt = r_taken ? S_PC_ONLY : S_NEXT_PC;
         S_CALL:    w_state_nxt = S_PC_ONLY;
         S_NEXT_PC: w_state_nxt = S_FETCH_A;
         S_PC_ONLY: w_state_nxt = S_FETCH_A;
         S_TRAP:    w_state_nxt = ET ? S_VECTOR : S_ERROR;
         S_VECTOR:  w_state_nxt = S_PC_ONLY;
         S_ERROR:   w_state_nxt = S_ERROR;
         default:   w_state_nxt = S_ERROR;
      endcase
      w_taken_nxt = (w_state_nxt == S_BRANCH) ? w_taken : r_taken;
   end

   // Moore output decode of the state being entered
   always_comb begin
      w_out_nxt = '0;
      case (w_state_nxt)
         S_FETCH_A: begin
            w_out_nxt.mar_sel = MAR_SEL_PC;
            w_out_nxt.mare    = 1'b1;
         end
         S_FETCH_R: begin
            w_out_nxt.mfa     = 1'b1;
            w_out_nxt.mop_sel = 1'b1;
            w_out_nxt.op1     = MOP_LD;
            w_out_nxt.mdr_sel = MDR_SEL_RAM;
            w_out_nxt.mdre    = 1'b1;
         end
         S_FETCH_I: w_out_nxt.ire = 1'b1;
         S_DECODE:  w_out_nxt = '0;
         S_ALU_EX: begin
            w_out_nxt.alue    = 1'b1;
            w_out_nxt.alu_sel = {1'b0, IR[13]};
            w_out_nxt.cin_sel = CIN_SEL_ALU;
            w_out_nxt.rc_sel  = RC_SEL_RD;
            w_out_nxt.rfe     = 1'b1;
         end
         S_LS_ADDR: begin
            w_out_nxt.alue    = 1'b1;
            w_out_nxt.aop_sel = 1'b1;
            w_out_nxt.op1     = AOP_ADD;
            w_out_nxt.alu_sel = {1'b0, IR[13]};
            w_out_nxt.mar_sel = MAR_SEL_ALU;
            w_out_nxt.mare    = 1'b1;
         end
         S_LD_WB: begin
            w_out_nxt.cin_sel = CIN_SEL_MDR;
            w_out_nxt.rc_sel  = RC_SEL_RD;
            w_out_nxt.rfe     = 1'b1;
         end
         S_ST_D: begin
            w_out_nxt.ra_sel  = 1'b1;
            w_out_nxt.mdr_sel = MDR_SEL_RFA;
            w_out_nxt.mdre    = 1'b1;
         end
         S_ST_W: begin
            w_out_nxt.mfa     = 1'b1;
            w_out_nxt.mop_sel = 1'b1;
            w_out_nxt.op1     = MOP_ST;
         end
         S_BRANCH: begin
            w_out_nxt.baux     = w_taken_nxt;
            w_out_nxt.disp_sel = DISP_22;
            w_out_nxt.npc_sel  = w_taken_nxt ? NPC_SEL_BR : NPC_SEL_INC;
            w_out_nxt.npce     = w_taken_nxt;
         end
         S_CALL: begin
            w_out_nxt.rc_sel   = RC_SEL_R15;
            w_out_nxt.cin_sel  = CIN_SEL_PC;
            w_out_nxt.rfe      = 1'b1;
            w_out_nxt.baux     = 1'b1;
            w_out_nxt.disp_sel = DISP_30;
            w_out_nxt.npc_sel  = NPC_SEL_BR;
            w_out_nxt.npce     = 1'b1;
         end
         S_NEXT_PC: begin
            w_out_nxt.pce     = 1'b1;
            w_out_nxt.npce    = 1'b1;
            w_out_nxt.npc_add = 1'b1;
            w_out_nxt.npc_sel = NPC_SEL_INC;
         end
         S_PC_ONLY: w_out_nxt.pce = 1'b1;
         S_TRAP: begin
            w_out_nxt.tqe   = 1'b1;
            w_out_nxt.tq_in = w_code_nxt;
         end
         S_VECTOR: begin
            w_out_nxt.npc_sel = NPC_SEL_TBR;
            w_out_nxt.npce    = 1'b1;
         end
         S_ERROR:   w_out_nxt.err_halt = 1'b1;
         default:   w_out_nxt = '0;
      endcase
   end

   // State, trap code, branch decision and output registers
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_state       <= S_FETCH_A;
         r_live        <= 1'b0;
         r_ld_pend     <= 1'b0;
         r_taken       <= 1'b0;
         r_code        <= 6'd0;
         r_out         <= '0;
         r_out.mar_sel <= MAR_SEL_PC;
      end else begin
         r_state   <= w_state_nxt;
         r_live    <= 1'b1;
         r_ld_pend <= w_ld_pend_nxt;
         r_taken   <= w_taken_nxt;
         r_code    <= w_code_nxt;
         r_out     <= w_out_nxt;
      end
   end

   // MFC watchdog: restart on entering a memory wait, count while waiting
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         r_wd <= '0;
      end else if (is_mem_wait(w_state_nxt) && (w_state_nxt != r_state)) begin
         r_wd <= '0;
      end else if (is_mem_wait(r_state)) begin
         r_wd <= r_wd + WD_W'(1);
      end else begin
         r_wd <= r_wd;
      end
   end

   assign IRE      = r_out.ire;
   assign MDRE     = r_out.mdre;
   assign MARE     = r_out.mare;
   assign PCE      = r_out.pce;
   assign nPCE     = r_out.npce;
   assign nPC_ADD  = r_out.npc_add;
   assign RFE      = r_out.rfe;
   assign ALUE     = r_out.alue;
   assign MFA      = r_out.mfa;
   assign MOP_SEL  = r_out.mop_sel;
   assign AOP_SEL  = r_out.aop_sel;
   assign RA_SEL   = r_out.ra_sel;
   assign BAUX     = r_out.baux;
   assign DISP_SEL = r_out.disp_sel;
   assign tQE      = r_out.tqe;
   assign nPC_SEL  = r_out.npc_sel;
   assign ALU_SEL  = r_out.alu_sel;
   assign CIN_SEL  = r_out.cin_sel;
   assign RC_SEL   = r_out.rc_sel;
   assign MAR_SEL  = r_out.mar_sel;
   assign MDR_SEL  = r_out.mdr_sel;
   assign OP1      = r_out.op1;
   assign tQ_IN    = r_out.tq_in;
   assign ErrHalt  = r_out.err_halt;
   assign State    = r_state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microsequencer directly upstream of the SPARC datapath; drives its enables, mux selects, memory strobes and trap-queue writes each cycle.
- Runs fetch, decode and a reduced SPARC subset: format-3 ALU ops, LD/ST word, Bicc, CALL.
- Waits on MFC with a watchdog and vectors to TBR on illegal/timeout traps.
- Datapath nPC_ADDSEL is tied 0 (+4 step) outside this block.

Parameters:
MFC_TIMEOUT, 16, cycles a memory wait state may last before a timeout trap (>=2)

Ports:
Clk  input  1  clock, rising edge
Clr  input  1  asynchronous active-low reset
IR  input  32  instruction register contents
PSR_icc  input  4  {N,Z,V,C} = PSR[23:20]
MFC  input  1  memory function complete
ET  input  1  traps enabled
IRE, MDRE, MARE, PCE, nPCE  output  1 each  register load enables
nPC_ADD  output  1  enable nPC+4 adder
RFE  output  1  register-file write
ALUE  output  1  ALU enable
MFA  output  1  memory function active
MOP_SEL  output  1  1 = memory opcode from OP1
AOP_SEL  output  1  1 = ALU opcode from OP1
RA_SEL  output  1  0 = rs1 IR[18:14], 1 = rd IR[29:25]
BAUX  output  1  branch-target adder enable
DISP_SEL  output  1  0 = disp22, 1 = disp30
tQE  output  1  trap-queue write
nPC_SEL  output  2  0 = nPC+4, 1 = TBR, 2 = branch target, 3 = ALU
ALU_SEL  output  2  0 = RF B, 1 = simm13
CIN_SEL  output  2  0 = PC, 1 = nPC, 2 = ALU, 3 = MDR
RC_SEL  output  2  0 = rd, 3 = r15
MAR_SEL  output  2  0 = ALU, 1 = PC
MDR_SEL  output  2  0 = RAM, 1 = RF A
OP1  output  6  memory/ALU opcode
tQ_IN  output  6  trap code
ErrHalt  output  1  error-mode halt flag
State  output  4  current state (debug)

Behaviour:
- Moore outputs decoded from State only; default 0. Reset value of every output is 0 except MAR_SEL = 1. State resets to FETCH_A.
- Clr low at any time clears state, watchdog counter and ErrHalt immediately.
- FETCH_A: MAR_SEL = 1, MARE = 1.
- FETCH_R: MFA = 1, MOP_SEL = 1, OP1 = MOP_LD, MDR_SEL = 0, MDRE = 1. Stay until MFC is sampled 1, then go to FETCH_I.
- FETCH_I: IRE = 1.
- DECODE: no outputs. Next state by IR[31:30]:
  - 10 -> ALU_EX.
  - 11 -> LS_ADDR.
  - 00 with IR[24:22] = 010 -> BRANCH.
  - 01 -> CALL.
  - Anything else -> TRAP with code TT_ILLEGAL.
- ALU_EX: ALUE = 1, AOP_SEL = 0, ALU_SEL = {0, IR[13]}, CIN_SEL = 2, RC_SEL = 0, RFE = 1. Next NEXT_PC.
- LS_ADDR: ALUE = 1, AOP_SEL = 1, OP1 = AOP_ADD, ALU_SEL = {0, IR[13]}, MAR_SEL = 0, MARE = 1.
  - IR[21] = 1 (store) -> ST_D.
  - Otherwise -> LD_R.
- LD_R: same as FETCH_R (MFA = 1, MOP_SEL = 1, OP1 = MOP_LD, MDR_SEL = 0, MDRE = 1); wait for MFC, then LD_WB.
- LD_WB: CIN_SEL = 3, RC_SEL = 0, RFE = 1. Next NEXT_PC.
- ST_D: RA_SEL = 1, MDR_SEL = 1, MDRE = 1.
- ST_W: MFA = 1, MOP_SEL = 1, OP1 = MOP_ST; wait for MFC, then NEXT_PC.
- BRANCH: evaluate cond IR[28:25] on PSR_icc using the full 16-entry SPARC icc table.
  - Taken: BAUX = 1, DISP_SEL = 0, nPC_SEL = 2, nPCE = 1, then PC_ONLY.
  - Not taken: go to NEXT_PC.
  - Annul bit is ignored.
- CALL: RC_SEL = 3, CIN_SEL = 0, RFE = 1, BAUX = 1, DISP_SEL = 1, nPC_SEL = 2, nPCE = 1. Next PC_ONLY.
- NEXT_PC: PCE = 1, nPCE = 1, nPC_ADD = 1, nPC_SEL = 0. Next FETCH_A.
- PC_ONLY: PCE = 1. Next FETCH_A.
- Watchdog:
  - Counter clears on entry to FETCH_R, LD_R or ST_W and increments each cycle spent there.
  - If it reaches MFC_TIMEOUT-1 with MFC = 0 -> TRAP with code TT_MEM.
  - MFC = 1 in that same cycle wins (no trap).
- TRAP: tQE = 1, tQ_IN = latched code.
  - ET = 1 -> VECTOR.
  - ET = 0 -> ERROR.
- VECTOR: nPC_SEL = 1, nPCE = 1. Next PC_ONLY.
- ERROR: ErrHalt = 1, all enables 0; held until Clr.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding (4-bit localparams);
  - MOP_LD = 6'b000000, MOP_ST = 6'b000100, AOP_ADD = 6'b000000;
  - TT_ILLEGAL = 6'd2, TT_MEM = 6'd9;
  - mux select constants.
- One sub-module: branch_cond_eval (cond[3:0], icc[3:0] -> taken), combinational, reused by a later annul/delay-slot stage.

Test Plan:
- Reset mid-FETCH_R with Clr low -> State = FETCH_A and all outputs at reset values in the same cycle; after release, FETCH_A shows MARE = 1, MAR_SEL = 1.
- ALU instruction IR = 0x8600A005 (add r3, r2, 5), MFC returned after 1 cycle -> FETCH_A, FETCH_R, FETCH_I, DECODE, ALU_EX (RFE = 1, ALU_SEL = 1, CIN_SEL = 2), NEXT_PC = 6 cycles.
- LD with MFC delayed 3 cycles in LD_R -> MDRE held 4 cycles, then LD_WB with CIN_SEL = 3; ST -> ST_D asserts RA_SEL = 1, MDR_SEL = 1, then ST_W with OP1 = 000100.
- Bicc BE (cond 0001):
  - with icc Z = 1 -> nPC_SEL = 2, nPCE, then PC_ONLY;
  - with Z = 0 -> NEXT_PC with nPC_ADD = 1.
- MFC held 0 for MFC_TIMEOUT cycles in FETCH_R:
  - ET = 1 -> TRAP with tQ_IN = 9, VECTOR (nPC_SEL = 1), PC_ONLY;
  - ET = 0 -> ERROR, ErrHalt = 1 until Clr.
- IR[31:30] = 00 with op2 = 111 -> TRAP with tQ_IN = 2; MFC rising exactly on the timeout cycle -> no trap.
